alsu_cmd_sequencer: RTL
=======================

Name: alsu_cmd_sequencer

Overview:
- Upstream command stage for the ALSU datapath.
- Buffers packed ALSU commands arriving over a valid/ready interface and issues at most one per cycle onto the ALSU input pins.
- Tracks each command through the ALSU's fixed pipeline latency, captures the registered ALSU output at the exact return cycle, and returns it with a tag and a locally computed invalid flag over a valid/ready response interface.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- RESP_DEPTH, 4: response FIFO entries; power of two, ≥2. Also the maximum number of in-flight plus unread results.
- LATENCY, 3: clock edges from the issue edge to the edge at which alsu_out is captured.
- INPUT_PRIORITY, "A": must match the downstream ALSU setting. Used only to document bypass precedence; affects no logic here.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_data  in  16  command fields: [15:13] opcode, [12:10] A, [9:7] B, [6] cin, [5] serial_in, [4] red_op_A, [3] red_op_B, [2] bypass_A, [1] bypass_B, [0] direction
- resp_valid  out  1  response FIFO not empty
- resp_ready  in  1  consumer accepts response
- resp_out  out  6  captured ALSU result, signed
- resp_tag  out  4  issue sequence number of this result
- resp_invalid  out  1  command was invalid and not bypassed
- alsu_opcode  out  3  to ALSU
- alsu_A  out  3  to ALSU
- alsu_B  out  3  to ALSU
- alsu_cin  out  1  to ALSU
- alsu_serial_in  out  1  to ALSU
- alsu_red_op_A  out  1  to ALSU
- alsu_red_op_B  out  1  to ALSU
- alsu_bypass_A  out  1  to ALSU
- alsu_bypass_B  out  1  to ALSU
- alsu_direction  out  1  to ALSU
- alsu_out  in  6  registered ALSU result
- busy  out  1  any command queued, in flight, or unread

Behaviour:
- Reset (async): both FIFOs empty, in-flight pipeline cleared, tag counter = 0, all alsu_* outputs = 0.
  - Resulting output values: cmd_ready = 1, resp_valid = 0, resp_out/resp_tag/resp_invalid = 0, busy = 0.
  - Reset mid-operation discards every queued, in-flight and unread command. No response is ever produced for those commands.
- Command accept: on an edge with cmd_valid & cmd_ready, the command is pushed.
  - cmd_ready = !cmd_full, registered-state derived; no combinational path from resp_ready.
  - When the FIFO is full, a same-cycle pop does not raise cmd_ready.
- Issue condition, evaluated every cycle: cmd FIFO not empty AND (inflight_count + resp_count) < RESP_DEPTH.
  - On an issue edge: pop the command, register all its fields onto the alsu_* outputs, push {tag, invalid_flag} into a LATENCY-deep valid/tag shift pipe, and increment tag (4 bits, wraps 15 -> 0).
  - Earliest issue is the edge after the accept edge; there is no same-cycle bypass.
  - Back-to-back issue at 1 command/cycle is supported.
- Idle hold: when not issuing, the alsu_* outputs keep the last issued values. Shift/rotate commands therefore keep evolving alsu_out while idle; only the capture edge defines a command's result.
- Capture: on the edge where the pipe's LATENCY-th stage is valid, push {alsu_out, tag, invalid_flag} into the response FIFO.
  - Credit accounting guarantees the response FIFO never overflows.
  - Simultaneous push and pop of the response FIFO is legal at any occupancy.
- invalid_flag = ((red_op_A|red_op_B) & (opcode[1]|opcode[2]) | (opcode[2]&opcode[1])) & !bypass_A & !bypass_B.
- Response: resp_* show the FIFO head; the entry is popped on an edge with resp_valid & resp_ready. Responses leave strictly in issue order.
- busy = cmd not empty | any pipe stage valid | resp not empty.

Test Plan:
- Add: push opcode=2, A=3, B=2, cin=1 at edge 0 -> issue at edge 1; resp_valid rises after edge 4 with resp_out=6, tag=0, invalid=0.
- Multiply, then XOR reduction, issued back-to-back:
  - A=-3 (3'b101), B=3, opcode 3 -> resp_out=6'h37 (-9), tag 0.
  - red_op_A=1, A=3'b110, opcode 1 -> resp_out=0, tag 1.
  - The two responses arrive on consecutive cycles.
- Invalid vs bypass:
  - opcode=6 -> resp_out=0, resp_invalid=1.
  - opcode=7, bypass_A=1, A=-2 -> resp_out=6'h3E, resp_invalid=0.
  - opcode=4, red_op_B=1 -> resp_invalid=1.
- Backpressure: resp_ready=0, push 8 commands.
  - Exactly 4 issue.
  - cmd_ready falls once 4 more are queued.
  - Raise resp_ready -> tags 0..7 returned in order with no loss or duplication.
- Reset with 3 commands in flight and 2 queued -> all outputs return to reset values immediately. A new command afterwards returns with tag 0.
- Tag wrap: 17 sequential commands -> the 17th response carries tag 0.

Source files
------------

// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer: buffers ALSU commands, issues one per cycle under result credit,
// and returns each captured alsu_out in issue order with its tag and invalid flag.
module alsu_cmd_sequencer #(
  parameter int    CMD_DEPTH      = 4,
  parameter int    RESP_DEPTH     = 4,
  parameter int    LATENCY        = 3,
  parameter string INPUT_PRIORITY = "A"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [5:0]  resp_out,
  output logic [3:0]  resp_tag,
  output logic        resp_invalid,
  output logic [2:0]  alsu_opcode,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  output logic        alsu_direction,
  input  logic [5:0]  alsu_out,
  output logic        busy
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RESP_DEPTH);
  logic [15:0]        cmd_mem_q [CMD_DEPTH];
  logic [10:0]        resp_mem_q [RESP_DEPTH];
  logic [CW-1:0]      cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CW:0]        cmd_cnt_q, cmd_cnt_d;
  logic [RW-1:0]      resp_wp_q, resp_wp_d, resp_rp_q, resp_rp_d;
  logic [RW:0]        resp_cnt_q, resp_cnt_d, credit_q, credit_d;
  logic [LATENCY-1:0] pipe_v_q, pipe_v_d;
  logic [4:0]         pipe_ti_q [LATENCY];
  logic [4:0]         pipe_ti_d [LATENCY];
  logic [3:0]         tag_q, tag_d;
  logic [15:0]        alsu_q, alsu_d, head;
  logic               cmd_push, issue, cap, resp_pop, inv, unused_prio;
  // bypass precedence lives in the ALSU; the setting is carried here for reference only
  assign unused_prio = INPUT_PRIORITY == "A";
  assign head        = cmd_mem_q[cmd_rp_q];
  assign cmd_ready   = cmd_cnt_q != (CW+1)'(CMD_DEPTH);
  assign cmd_push    = cmd_valid & cmd_ready;
  // credit counts in-flight plus unread results, so the response FIFO can never overflow
  assign issue       = |cmd_cnt_q & (credit_q != (RW+1)'(RESP_DEPTH));
  assign cap         = pipe_v_q[LATENCY-1];
  assign resp_valid  = |resp_cnt_q;
  assign resp_pop    = resp_valid & resp_ready;
  assign inv         = ((head[4] | head[3]) & (head[14] | head[15]) | (head[15] & head[14])) & ~head[2] & ~head[1];
  assign busy        = |cmd_cnt_q | |credit_q;
  assign {resp_out, resp_tag, resp_invalid} = resp_valid ? resp_mem_q[resp_rp_q] : '0;
  assign {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_red_op_A,
          alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction} = alsu_q;
  always_comb begin
    cmd_wp_d     = cmd_wp_q + CW'(cmd_push);
    cmd_rp_d     = cmd_rp_q + CW'(issue);
    cmd_cnt_d    = cmd_cnt_q + (CW+1)'(cmd_push) - (CW+1)'(issue);
    resp_wp_d    = resp_wp_q + RW'(cap);
    resp_rp_d    = resp_rp_q + RW'(resp_pop);
    resp_cnt_d   = resp_cnt_q + (RW+1)'(cap) - (RW+1)'(resp_pop);
    credit_d     = credit_q + (RW+1)'(issue) - (RW+1)'(resp_pop);
    tag_d        = tag_q + 4'(issue);
    alsu_d       = issue ? head : alsu_q;
    pipe_v_d     = LATENCY'({pipe_v_q, issue});
    pipe_ti_d[0] = {tag_q, inv};
    for (int i = 1; i < LATENCY; i++) pipe_ti_d[i] = pipe_ti_q[i-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wp_q   <= '0;
      cmd_rp_q   <= '0;
      cmd_cnt_q  <= '0;
      resp_wp_q  <= '0;
      resp_rp_q  <= '0;
      resp_cnt_q <= '0;
      credit_q   <= '0;
      tag_q      <= '0;
      alsu_q     <= '0;
      pipe_v_q   <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_ti_q[i] <= '0;
    end else begin
      cmd_wp_q   <= cmd_wp_d;
      cmd_rp_q   <= cmd_rp_d;
      cmd_cnt_q  <= cmd_cnt_d;
      resp_wp_q  <= resp_wp_d;
      resp_rp_q  <= resp_rp_d;
      resp_cnt_q <= resp_cnt_d;
      credit_q   <= credit_d;
      tag_q      <= tag_d;
      alsu_q     <= alsu_d;
      pipe_v_q   <= pipe_v_d;
      for (int i = 0; i < LATENCY; i++) pipe_ti_q[i] <= pipe_ti_d[i];
    end
  end
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wp_q] <= cmd_data;
    if (cap) resp_mem_q[resp_wp_q] <= {alsu_out, pipe_ti_q[LATENCY-1]};
  end
endmodule
